mcu_spi_target: RTL and testbench

SPI target (slave) peripheral: the receiving end of the MCU SPI link, letting an external SPI controller clock bytes into and out of the MCU. SCLK/MOSI/CS are sampled on `clk_in` through 2-FF synchronizers. Received bytes are buffered for the CPU, and a CPU-loaded byte is shifted out on MISO. It sits on the same 3-bit peripheral memory bus as the other MCU peripherals.

---
 rtl/mcu_spi_target_if.sv | 36 +++
 rtl/mcu_spi_target.sv | 210 +++++++++++++++++++++
 tb/tb_mcu_spi_target.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_spi_target_if.sv
// mcu_spi_target_if
// Purpose: 3-bit peripheral memory bus shared by the MCU peripherals.
// Signals:
//   periph_data_out       : read data returned by the peripheral (registered)
//   periph_data_valid_out : read data valid, one cycle after a read request
//   periph_data_in        : write data from the CPU
//   periph_addr_in        : register address
//   periph_addr_valid_in  : request strobe
//   periph_write_en_in    : 1 = write, 0 = read
// Modports: master (CPU side), slave (peripheral side).
interface mcu_spi_target_if;
  logic [7:0] periph_data_out;
  logic       periph_data_valid_out;
  logic [7:0] periph_data_in;
  logic [2:0] periph_addr_in;
  logic       periph_addr_valid_in;
  logic       periph_write_en_in;

  modport master (
    input  periph_data_out,
    input  periph_data_valid_out,
    output periph_data_in,
    output periph_addr_in,
    output periph_addr_valid_in,
    output periph_write_en_in
  );

  modport slave (
    output periph_data_out,
    output periph_data_valid_out,
    input  periph_data_in,
    input  periph_addr_in,
    input  periph_addr_valid_in,
    input  periph_write_en_in
  );
endinterface

// File: rtl/mcu_spi_target.sv
// mcu_spi_target
// Purpose: SPI target (mode 0). An external controller clocks bytes in on
// MOSI and out on MISO; received bytes are buffered for the CPU and the CPU
// supplies the next outgoing byte through a holding register.
// Ports:
//   clk_in, reset_in      : system clock, asynchronous active-high reset
//   sclk_in/mosi_in/cs_in : external SPI pins (CS active low), synchronized
//   miso_out, miso_oe_out : target data out (MSB first) and its enable
//   irq_out               : rx_not_empty | overrun
//   bus                   : peripheral bus (slave modport)
// Registers: 0 RX data (pop), 1 TX data, 2 status, 3 RX level, 4 default TX.
// Build option MCU_SPI_TARGET_RX_FIFO_EN: defined gives a 4-entry RX FIFO,
// undefined gives a single RX holding byte.
module mcu_spi_target (
  input  logic clk_in,
  input  logic reset_in,
  input  logic sclk_in,
  input  logic mosi_in,
  input  logic cs_in,
  output logic miso_out,
  output logic miso_oe_out,
  output logic irq_out,
  mcu_spi_target_if.slave bus
);

`ifdef MCU_SPI_TARGET_RX_FIFO_EN
  localparam logic [2:0] RX_DEPTH = 3'd4;
  localparam logic [1:0] PTR_STEP = 2'd1;
`else
  // Single holding byte: pointers never move, so only entry 0 is used.
  localparam logic [2:0] RX_DEPTH = 3'd1;
  localparam logic [1:0] PTR_STEP = 2'd0;
`endif

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_mosi_s1, r_mosi_s2, r_mosi_d;
  logic r_cs_s1, r_cs_s2, r_cs_d;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic [7:0] r_tx_hold;
  logic [7:0] r_tx_default;
  logic       r_tx_full;
  logic       r_overrun;
  logic       r_underrun;
  logic       r_miso_oe;
  logic [7:0] r_rx_mem [4];
  logic [1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0] r_level;
  logic [7:0] r_rd_data;
  logic       r_rd_valid;

  logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_active, w_stay;
  logic       w_bus_rd, w_bus_wr, w_rx_not_empty, w_rx_full, w_pop;
  logic       w_byte_done, w_push, w_drop, w_load, w_busy;
  logic       w_wr_tx, w_wr_status, w_wr_default;
  logic [7:0] w_load_byte, w_status, w_rd_mux;

  assign w_sclk_rise    = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall    = ~r_sclk_s2 & r_sclk_d;
  assign w_cs_fall      = ~r_cs_s2 & r_cs_d;
  assign w_active       = (r_state == ST_ACTIVE);
  // SCLK edges only count while the synchronized CS is still low.
  assign w_stay         = w_active & ~r_cs_s2;

  assign w_bus_rd       = bus.periph_addr_valid_in & ~bus.periph_write_en_in;
  assign w_bus_wr       = bus.periph_addr_valid_in & bus.periph_write_en_in;
  assign w_wr_tx        = w_bus_wr & (bus.periph_addr_in == 3'd1);
  assign w_wr_status    = w_bus_wr & (bus.periph_addr_in == 3'd2);
  assign w_wr_default   = w_bus_wr & (bus.periph_addr_in == 3'd4);

  assign w_rx_not_empty = (r_level != 3'd0);
  assign w_rx_full      = (r_level == RX_DEPTH);
  assign w_pop          = w_bus_rd & (bus.periph_addr_in == 3'd0) & w_rx_not_empty;
  assign w_byte_done    = w_stay & w_sclk_rise & (r_bit_cnt == 3'd7);
  // A same-cycle pop frees a slot, so a full buffer still accepts the byte.
  assign w_push         = w_byte_done & (~w_rx_full | w_pop);
  assign w_drop         = w_byte_done & w_rx_full & ~w_pop;

  // TX shifter loads on CS assertion and at each byte boundary falling edge.
  assign w_load         = (~w_active & w_cs_fall) |
                          (w_stay & w_sclk_fall & (r_bit_cnt == 3'd0));
  assign w_load_byte    = r_tx_full ? r_tx_hold : r_tx_default;
  assign w_busy         = w_active & (r_bit_cnt != 3'd0);
  assign w_status       = {1'b0, r_underrun, w_busy, w_active,
                           r_tx_full, r_overrun, w_rx_full, w_rx_not_empty};

  always_comb begin
    w_rd_mux = 8'h00;
    case (bus.periph_addr_in)
      3'd0:    w_rd_mux = w_rx_not_empty ? r_rx_mem[r_rd_ptr] : 8'h00;
      3'd1:    w_rd_mux = r_tx_hold;
      3'd2:    w_rd_mux = w_status;
      3'd3:    w_rd_mux = {5'd0, r_level};
      3'd4:    w_rd_mux = r_tx_default;
      default: w_rd_mux = 8'h00;
    endcase
  end

  // RX storage needs no reset: r_level says which entries are valid.
  always_ff @(posedge clk_in) begin
    if (w_push) r_rx_mem[r_wr_ptr] <= {r_rx_sh, r_mosi_d};
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_sclk_s1    <= 1'b0;
      r_sclk_s2    <= 1'b0;
      r_sclk_d     <= 1'b0;
      r_mosi_s1    <= 1'b0;
      r_mosi_s2    <= 1'b0;
      r_mosi_d     <= 1'b0;
      r_cs_s1      <= 1'b1;
      r_cs_s2      <= 1'b1;
      r_cs_d       <= 1'b1;
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_rx_sh      <= 7'd0;
      r_tx_sh      <= 8'h00;
      r_tx_hold    <= 8'h00;
      r_tx_default <= 8'hFF;
      r_tx_full    <= 1'b0;
      r_overrun    <= 1'b0;
      r_underrun   <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_level      <= 3'd0;
      r_rd_data    <= 8'h00;
      r_rd_valid   <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk_in;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= mosi_in;
      r_mosi_s2 <= r_mosi_s1;
      r_mosi_d  <= r_mosi_s2;
      r_cs_s1   <= cs_in;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;

      r_rd_valid <= w_bus_rd;
      if (w_bus_rd) r_rd_data <= w_rd_mux;

      // A CPU write in the same cycle as an engine load wins: the engine
      // has already taken the old value (or the default byte).
      if (w_wr_tx) begin
        r_tx_hold <= bus.periph_data_in;
        r_tx_full <= 1'b1;
      end else if (w_load) begin
        r_tx_full <= 1'b0;
      end
      if (w_wr_default) r_tx_default <= bus.periph_data_in;

      // Sticky flags: a new event beats a same-cycle clear.
      if (w_drop)
        r_overrun <= 1'b1;
      else if (w_wr_status && bus.periph_data_in[2])
        r_overrun <= 1'b0;
      if (w_load && !r_tx_full)
        r_underrun <= 1'b1;
      else if (w_wr_status && bus.periph_data_in[6])
        r_underrun <= 1'b0;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_STEP;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_STEP;
      r_level <= r_level + {2'd0, w_push} - {2'd0, w_pop};

      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= 3'd0;
          if (w_cs_fall) begin
            r_state   <= ST_ACTIVE;
            r_miso_oe <= 1'b1;
            r_tx_sh   <= w_load_byte;
          end
        end
        ST_ACTIVE: begin
          if (r_cs_s2) begin
            // CS released: any partial byte is simply abandoned.
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_miso_oe <= 1'b0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_sh   <= {r_rx_sh[5:0], r_mosi_d};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_sclk_fall) begin
              if (r_bit_cnt == 3'd0) r_tx_sh <= w_load_byte;
              else                   r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso_out                  = w_active & r_tx_sh[7];
  assign miso_oe_out               = r_miso_oe;
  assign irq_out                   = w_rx_not_empty | r_overrun;
  assign bus.periph_data_out       = r_rd_data;
  assign bus.periph_data_valid_out = r_rd_valid;

endmodule

// File: tb/tb_mcu_spi_target.sv
// tb_mcu_spi_target
// Purpose: self-checking bench for mcu_spi_target. A queue-based model of the
// RX buffer, TX holding register and sticky flags predicts every value read
// back from the bus and every byte seen on MISO.
module tb_mcu_spi_target;
  localparam int HALF = 6;
`ifdef MCU_SPI_TARGET_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk_in = 1'b0;
  logic reset_in, sclk_in, mosi_in, cs_in;
  logic miso_out, miso_oe_out, irq_out;

  mcu_spi_target_if bus_if();

  mcu_spi_target dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .sclk_in     (sclk_in),
    .mosi_in     (mosi_in),
    .cs_in       (cs_in),
    .miso_out    (miso_out),
    .miso_oe_out (miso_oe_out),
    .irq_out     (irq_out),
    .bus         (bus_if)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model
  bq_t        m_q;
  bit         m_overrun, m_underrun, m_hold_full;
  logic [7:0] m_hold, m_default;

  task automatic m_reset();
    m_q.delete();
    m_overrun = 0; m_underrun = 0; m_hold_full = 0;
    m_hold = 8'h00; m_default = 8'hFF;
  endtask

  task automatic model_load(output logic [7:0] b);
    b = m_hold_full ? m_hold : m_default;
    if (!m_hold_full) m_underrun = 1;
    m_hold_full = 0;
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_overrun = 1;
  endtask

  function automatic logic [7:0] m_status();
    return {1'b0, m_underrun, 2'b00, m_hold_full, m_overrun,
            m_q.size() == DEPTH, m_q.size() != 0};
  endfunction

  function automatic logic [7:0] m_pop();
    if (m_q.size() == 0) return 8'h00;
    return m_q.pop_front();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output logic v);
    bus_if.periph_addr_in       = a;
    bus_if.periph_write_en_in   = 1'b0;
    bus_if.periph_addr_valid_in = 1'b1;
    tick(1);
    d = bus_if.periph_data_out;
    v = bus_if.periph_data_valid_out;
    bus_if.periph_addr_valid_in = 1'b0;
  endtask

  // CPU write that also updates the model's view of the register file.
  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    bus_if.periph_addr_in       = a;
    bus_if.periph_data_in       = d;
    bus_if.periph_write_en_in   = 1'b1;
    bus_if.periph_addr_valid_in = 1'b1;
    tick(1);
    bus_if.periph_addr_valid_in = 1'b0;
    bus_if.periph_write_en_in   = 1'b0;
    case (a)
      3'd1: begin m_hold = d; m_hold_full = 1; end
      3'd2: begin if (d[2]) m_overrun = 0; if (d[6]) m_underrun = 0; end
      3'd4: m_default = d;
      default: ;
    endcase
  endtask

  // Clock nbits out of tx; capture MISO just before each rising edge. With
  // pop_last, an RX read is issued in the cycle the last bit is acted on.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit pop_last,
                          output logic [7:0] rx, output logic [7:0] popped);
    rx = 8'h00; popped = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi_in = tx[7-i];
      tick(HALF);
      rx = {rx[6:0], miso_out};
      sclk_in = 1'b1;
      if (pop_last && i == nbits - 1) begin
        tick(2);
        bus_if.periph_addr_in       = 3'd0;
        bus_if.periph_write_en_in   = 1'b0;
        bus_if.periph_addr_valid_in = 1'b1;
        tick(1);
        popped = bus_if.periph_data_out;
        bus_if.periph_addr_valid_in = 1'b0;
        tick(HALF - 3);
      end else begin
        tick(HALF);
      end
      sclk_in = 1'b0;
    end
  endtask

  // One CS-framed transfer of whole bytes; returns captured and expected MISO.
  task automatic frame(input bq_t tx_bytes, output bq_t got, output bq_t exp);
    logic [7:0] e, r, p;
    got.delete(); exp.delete();
    cs_in = 1'b0;
    model_load(e);
    tick(HALF);
    foreach (tx_bytes[k]) begin
      exp.push_back(e);
      spi_bits(tx_bytes[k], 8, 1'b0, r, p);
      got.push_back(r);
      model_rx(tx_bytes[k]);
      model_load(e);
    end
    tick(HALF);
    cs_in = 1'b1;
    tick(HALF);
  endtask

  task automatic test_reset();
    logic [7:0] d; logic v;
    reset_in = 1'b1; cs_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0;
    bus_if.periph_addr_valid_in = 1'b0; bus_if.periph_write_en_in = 1'b0;
    bus_if.periph_addr_in = 3'd0; bus_if.periph_data_in = 8'h00;
    tick(3);
    checks++;
    if ({miso_out, miso_oe_out, irq_out, bus_if.periph_data_valid_out} !== 4'b0000 ||
        bus_if.periph_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got miso=%b oe=%b irq=%b valid=%b data=%h, expected all 0",
               miso_out, miso_oe_out, irq_out, bus_if.periph_data_valid_out, bus_if.periph_data_out);
    end
    reset_in = 1'b0;
    m_reset();
    tick(2);
    bus_read(3'd2, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", d); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL read_valid: got %b expected 1", v); end
    tick(1);
    checks++;
    if (bus_if.periph_data_valid_out !== 1'b0) begin
      errors++; $display("FAIL valid_idle: got %b expected 0", bus_if.periph_data_valid_out);
    end
    bus_read(3'd4, d, v);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL reset_default: got %h expected ff", d); end
    bus_read(3'd3, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_level: got %h expected 00", d); end
    write_reg(3'd6, 8'h77);
    bus_read(3'd6, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unused_addr: got %h expected 00", d); end
  endtask

  task automatic test_basic();
    bq_t tx, got, exp; logic [7:0] d, e; logic v;
    write_reg(3'd1, 8'h3C);
    tx = '{8'hA5};
    frame(tx, got, exp);
    checks++; if (got[0] !== 8'h3C) begin errors++; $display("FAIL basic_miso: got %h expected 3c", got[0]); end
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL basic_irq_set: got %b expected 1", irq_out); end
    bus_read(3'd2, d, v);
    checks++; if (d !== m_status()) begin errors++; $display("FAIL basic_status: got %h expected %h", d, m_status()); end
    bus_read(3'd0, d, v);
    e = m_pop();
    checks++; if (d !== 8'hA5 || d !== e) begin errors++; $display("FAIL basic_rx: got %h expected %h", d, e); end
    bus_read(3'd3, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL basic_level: got %h expected 00", d); end
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL basic_irq_clear: got %b expected 0", irq_out); end
  endtask

  task automatic test_underrun();
    bq_t tx, got, exp; logic [7:0] d, e; logic v;
    write_reg(3'd2, 8'h44);
    write_reg(3'd4, 8'h81);
    tx = '{8'($urandom)};
    frame(tx, got, exp);
    checks++; if (got[0] !== 8'h81) begin errors++; $display("FAIL underrun_miso: got %h expected 81", got[0]); end
    bus_read(3'd2, d, v);
    checks++; if (d[6] !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b expected 1", d[6]); end
    write_reg(3'd2, 8'h40);
    bus_read(3'd2, d, v);
    checks++; if (d[6] !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b expected 0", d[6]); end
    bus_read(3'd0, d, v);
    e = m_pop();
    checks++; if (d !== e) begin errors++; $display("FAIL underrun_rx: got %h expected %h", d, e); end
  endtask

  task automatic test_overrun();
    bq_t tx, got, exp; logic [7:0] d, e; logic v;
    tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    frame(tx, got, exp);
    bus_read(3'd3, d, v);
    checks++; if (d !== 8'(DEPTH)) begin errors++; $display("FAIL overrun_level: got %h expected %h", d, 8'(DEPTH)); end
    bus_read(3'd2, d, v);
    checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", d[2]); end
    for (int i = 0; i <= DEPTH; i++) begin
      bus_read(3'd0, d, v);
      e = (i < DEPTH) ? 8'(i + 1) : 8'h00;
      checks++; if (d !== e) begin errors++; $display("FAIL overrun_pop%0d: got %h expected %h", i, d, e); end
      void'(m_pop());
    end
    write_reg(3'd2, 8'h44);
  endtask

  task automatic test_cs_abort();
    bq_t tx, got, exp; logic [7:0] d, e, r, p; logic v;
    cs_in = 1'b0;
    model_load(e);
    tick(HALF);
    spi_bits(8'($urandom), 5, 1'b0, r, p);
    tick(2);
    bus_read(3'd2, d, v);
    checks++; if (d[5:4] !== 2'b11) begin errors++; $display("FAIL abort_busy_mid: got %b expected 11", d[5:4]); end
    cs_in = 1'b1;
    tick(HALF);
    bus_read(3'd2, d, v);
    checks++; if (d[5:4] !== 2'b00) begin errors++; $display("FAIL abort_busy_idle: got %b expected 00", d[5:4]); end
    tx = '{8'h5A};
    frame(tx, got, exp);
    bus_read(3'd3, d, v);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL abort_level: got %h expected 01", d); end
    bus_read(3'd0, d, v);
    e = m_pop();
    checks++; if (d !== 8'h5A || d !== e) begin errors++; $display("FAIL abort_rx: got %h expected 5a", d); end
    write_reg(3'd2, 8'h44);
  endtask

  task automatic test_async_reset();
    bq_t tx, got, exp; logic [7:0] d, e, r, p; logic v;
    write_reg(3'd4, 8'h5E);
    tx = '{8'($urandom)};
    frame(tx, got, exp);
    bus_read(3'd4, d, v);
    cs_in = 1'b0;
    tick(HALF);
    spi_bits(8'($urandom), 3, 1'b0, r, p);
    checks++;
    if (miso_oe_out !== 1'b1 || irq_out !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got oe=%b irq=%b expected 1 1", miso_oe_out, irq_out);
    end
    #2 reset_in = 1'b1;
    #1;
    checks++;
    if ({miso_out, miso_oe_out, irq_out, bus_if.periph_data_valid_out} !== 4'b0000 ||
        bus_if.periph_data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got miso=%b oe=%b irq=%b valid=%b data=%h, expected all 0",
               miso_out, miso_oe_out, irq_out, bus_if.periph_data_valid_out, bus_if.periph_data_out);
    end
    cs_in = 1'b1; sclk_in = 1'b0;
    tick(2);
    #2 reset_in = 1'b0;
    m_reset();
    tick(3);
    tx = '{8'hC3};
    frame(tx, got, exp);
    checks++; if (got[0] !== exp[0]) begin errors++; $display("FAIL post_reset_miso: got %h expected %h", got[0], exp[0]); end
    bus_read(3'd2, d, v);
    checks++; if (d !== m_status()) begin errors++; $display("FAIL post_reset_status: got %h expected %h", d, m_status()); end
    bus_read(3'd0, d, v);
    e = m_pop();
    checks++; if (d !== 8'hC3 || d !== e) begin errors++; $display("FAIL post_reset_rx: got %h expected c3", d); end
    write_reg(3'd2, 8'h44);
  endtask

  task automatic test_pop_collision();
    bq_t tx, got, exp; logic [7:0] d, e, r, p, b; logic v;
    tx.delete();
    for (int i = 0; i < DEPTH; i++) tx.push_back(8'($urandom));
    frame(tx, got, exp);
    b = 8'($urandom);
    cs_in = 1'b0;
    model_load(e);
    tick(HALF);
    spi_bits(b, 8, 1'b1, r, p);
    e = m_pop();
    model_rx(b);
    model_load(d);
    tick(HALF);
    cs_in = 1'b1;
    tick(HALF);
    checks++; if (p !== e) begin errors++; $display("FAIL collide_pop: got %h expected %h", p, e); end
    bus_read(3'd3, d, v);
    checks++; if (d !== 8'(DEPTH)) begin errors++; $display("FAIL collide_level: got %h expected %h", d, 8'(DEPTH)); end
    bus_read(3'd2, d, v);
    checks++; if (d[2] !== 1'b0) begin errors++; $display("FAIL collide_overrun: got %b expected 0", d[2]); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(3'd0, d, v);
      e = m_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL collide_order%0d: got %h expected %h", i, d, e); end
    end
    write_reg(3'd2, 8'h44);
  endtask

  task automatic test_random();
    bq_t tx, got, exp; logic [7:0] d, e; logic v; int n;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(1, 0) == 1) write_reg(3'd1, 8'($urandom));
      if ($urandom_range(2, 0) == 0) write_reg(3'd4, 8'($urandom));
      bus_read(3'd1, d, v);
      checks++; if (d !== m_hold) begin errors++; $display("FAIL rand%0d_hold: got %h expected %h", it, d, m_hold); end
      n = $urandom_range(3, 1);
      tx.delete();
      for (int k = 0; k < n; k++) tx.push_back(8'($urandom));
      frame(tx, got, exp);
      for (int k = 0; k < n; k++) begin
        checks++;
        if (got[k] !== exp[k]) begin errors++; $display("FAIL rand%0d_miso%0d: got %h expected %h", it, k, got[k], exp[k]); end
      end
      bus_read(3'd3, d, v);
      checks++; if (d !== 8'(m_q.size())) begin errors++; $display("FAIL rand%0d_level: got %h expected %h", it, d, 8'(m_q.size())); end
      bus_read(3'd2, d, v);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL rand%0d_status: got %h expected %h", it, d, m_status()); end
      if ($urandom_range(1, 0) == 1 || it == 7) begin
        while (m_q.size() != 0) begin
          bus_read(3'd0, d, v);
          e = m_pop();
          checks++; if (d !== e) begin errors++; $display("FAIL rand%0d_rx: got %h expected %h", it, d, e); end
        end
      end
      write_reg(3'd2, 8'h44);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_cs_abort();
    test_async_reset();
    test_pop_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
